keypad_key_capture: RTL
=======================

Name: keypad_key_capture

Overview:
- Consumes the keypad scanner's per-column Mealy outputs (PRESS, 4-bit DATA) and its last-column drive (D), one column per clk.
- Builds a per-frame key summary, one frame being four scan columns, and debounces it across frames.
- Emits exactly one 4-bit key code per physical press into a small FWFT FIFO that the MCU reads through an input port.
- Raises a one-cycle interrupt pulse per accepted key.

Parameters:
- DEBOUNCE_FRAMES, 3, consecutive identical frames required to accept a press or confirm a release (legal range 1..15).
- DEPTH, 4, FIFO entries (power of 2, ≥2).

Ports:
- clk  input  1  system clock; the scanner advances one column per clk.
- reset_n  input  1  asynchronous, active-low reset.
- press  input  1  scanner PRESS for the current column.
- data  input  4  scanner DATA; ignored when press=0.
- col_last  input  1  scanner last-column drive (D); high on the final column cycle of each frame.
- key_rd  input  1  MCU pop request; honoured only when key_valid=1.
- ovf_clr  input  1  clears the overflow flag.
- key_valid  output  1  FIFO non-empty.
- key_data  output  4  FIFO head (FWFT); 0 when empty.
- key_count  output  $clog2(DEPTH)+1  number of FIFO entries.
- overflow  output  1  sticky flag: a key was dropped because the FIFO was full.
- intr  output  1  one-cycle pulse per key pushed.

Behaviour:
- Reset, asynchronous: FSM=IDLE; cnt=0; cand=0; acc_hit=0; acc_code=0; FIFO empty; key_valid=0; key_data=0; key_count=0; overflow=0; intr=0.
- Frame accumulation, every cycle with col_last=0:
  - If press=1 and acc_hit=0, then acc_hit←1 and acc_code←data. The first column hit in a frame wins; later hits in that frame are ignored.
- Frame end, the cycle with col_last=1:
  - f_hit = acc_hit | press.
  - f_code = acc_hit ? acc_code : data.
  - Accumulators clear on the same edge.
  - The FSM evaluates only on this cycle.
- FSM states (enum IDLE, DEB_PRESS, HELD, DEB_REL), evaluated at frame end:
  - IDLE:
    - f_hit → cand←f_code, cnt←1, go DEB_PRESS.
    - If DEBOUNCE_FRAMES=1: accept immediately and go HELD instead.
  - DEB_PRESS:
    - f_hit with f_code==cand → cnt++. When cnt reaches DEBOUNCE_FRAMES: accept, go HELD.
    - f_hit with f_code≠cand → cand←f_code, cnt←1.
    - !f_hit → IDLE, cnt←0.
  - HELD:
    - f_hit (any code) → stay; no new push.
    - !f_hit → cnt←1, go DEB_REL. If DEBOUNCE_FRAMES=1, go straight to IDLE.
  - DEB_REL:
    - !f_hit → cnt++. When cnt reaches DEBOUNCE_FRAMES: go IDLE.
    - f_hit → go HELD, cnt←0. This is bounce on release; no new key.
- Accept:
  - Push cand into the FIFO on the frame-end edge.
  - key_valid/key_data/key_count update on that edge.
  - intr=1 for exactly the following cycle (registered from the push-success signal).
- FIFO, sub-module key_fifo:
  - Circular buffer; ptrs wrap modulo DEPTH.
  - Pop when key_rd & key_valid; key_rd while empty is ignored.
  - Push and pop in the same cycle when full: both succeed, count unchanged, no overflow.
  - Push when full with no pop: entry dropped, overflow←1, intr stays 0.
  - Push and pop in the same cycle when empty: push succeeds, pop ignored.
  - ovf_clr clears overflow. If it coincides with a new overflow event, set wins.
- Widths: cnt is 4 bits and saturates at DEBOUNCE_FRAMES; key_count spans 0..DEPTH inclusive.
- Reset mid-debounce or mid-frame: all state is discarded and accumulation restarts at the next cycle. There is no partial-frame carry.

Decomposition:
- keypad_pkg holds:
  - typedef enum logic[1:0] {IDLE, DEB_PRESS, HELD, DEB_REL} cap_state_t
  - KEY_W=4
  - typedef logic[KEY_W-1:0] key_t
- Sub-module key_fifo #(DEPTH, KEY_W) contains the push/pop/count/overflow logic.
- The top-level block holds the frame accumulator, the FSM and the intr register.

Test Plan:
- Key 5 held for 3 frames (press=1, data=5 on column 2; col_last every 4th cycle), DEBOUNCE_FRAMES=3 → after the 3rd col_last edge: key_valid=1, key_data=5, key_count=1, intr high one cycle.
- Bounce pattern hit/none/hit/hit/none for key 2 → nothing pushed, key_count=0, intr never asserted.
- Key 9 held 20 frames, release 2 frames, hold 5 frames → exactly one entry (9). Then release 3 frames and press 9 for 3 frames → second entry; key_count=2.
- Code 7 for 2 frames, then 8 for 3 frames → single entry 8; then key_rd=1 → key_valid=0, key_count=0.
- Five accepted keys 1,2,3,4,6 with no reads (DEPTH=4) → key_count=4, overflow=1, key_data=1. Four key_rd pops give 1,2,3,4; pulse ovf_clr → overflow=0. Also check push+pop when full → count stays 4, no overflow.
- reset_n low mid-DEB_PRESS with 2 entries queued → all outputs 0 immediately (async). After release of reset, a fresh 3-frame press of 0 is accepted normally (key_data=0, key_valid=1).

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types for the keypad key-capture slice: capture FSM states and key code type.
package keypad_pkg;

  localparam int KEY_W = 4;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {IDLE, DEB_PRESS, HELD, DEB_REL} cap_state_t;
  typedef logic [KEY_W-1:0] key_t;

endpackage

// File: rtl/key_fifo.sv
// Small first-word-fall-through key FIFO with a sticky overflow flag.
module key_fifo #(
  parameter int DEPTH = 4,
  parameter int KEY_W = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic [KEY_W-1:0]       push_data,
  input  logic                   pop,
  input  logic                   ovf_clr,
  output logic                   valid,
  output logic [KEY_W-1:0]       head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   push_ok
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [KEY_W-1:0] mem_q [DEPTH];
  logic [KEY_W-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             empty, full, pop_ok, drop;

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == FULL_CNT);
    pop_ok   = pop & ~empty;
    // A full FIFO still accepts a push when a pop frees a slot on the same edge.
    push_ok  = push & (~full | pop_ok);
    drop     = push & full & ~pop_ok;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;

    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (ovf_clr) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  assign valid    = ~empty;
  assign head     = empty ? '0 : mem_q[rd_ptr_q];
  assign count    = count_q;
  assign overflow = ovf_q;

endmodule

// File: rtl/keypad_key_capture.sv
// Keypad key capture: per-frame key summary, frame-level press/release debounce,
// key FIFO for the MCU and a one-cycle interrupt per queued key.
//
//   state     | meaning
//   ----------+--------------------------------------------------------
//   IDLE      | no key down; waiting for a frame with a hit
//   DEB_PRESS | same code seen for cnt frames; accept at DEBOUNCE_FRAMES
//   HELD      | key accepted and still down; no further pushes
//   DEB_REL   | no hit for cnt frames; released at DEBOUNCE_FRAMES
module keypad_key_capture
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 3,
  parameter int DEPTH           = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   press,
  input  logic [3:0]             data,
  input  logic                   col_last,
  input  logic                   key_rd,
  input  logic                   ovf_clr,
  output logic                   key_valid,
  output logic [3:0]             key_data,
  output logic [$clog2(DEPTH):0] key_count,
  output logic                   overflow,
  output logic                   intr
);

  localparam logic [CNT_W-1:0] DEB_N = CNT_W'(DEBOUNCE_FRAMES);

  cap_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  key_t             cand_q, cand_d;
  logic             acc_hit_q, acc_hit_d;
  key_t             acc_code_q, acc_code_d;
  logic             intr_q, intr_d;
  logic             f_hit;
  key_t             f_code;
  logic             push;
  logic             push_ok;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cand_d     = cand_q;
    acc_hit_d  = acc_hit_q;
    acc_code_d = acc_code_q;
    push       = 1'b0;
    cnt_inc    = (cnt_q >= DEB_N) ? DEB_N : cnt_q + 1'b1;
    f_hit      = acc_hit_q | press;
    f_code     = acc_hit_q ? acc_code_q : data;

    if (!col_last) begin
      // First hit column of the frame wins.
      if (press && !acc_hit_q) begin
        acc_hit_d  = 1'b1;
        acc_code_d = data;
      end
    end else begin
      acc_hit_d  = 1'b0;
      acc_code_d = '0;
      unique case (state_q)
        IDLE: begin
          if (f_hit) begin
            cand_d = f_code;
            cnt_d  = 4'd1;
            if (DEB_N == 4'd1) begin
              push    = 1'b1;
              state_d = HELD;
            end else begin
              state_d = DEB_PRESS;
            end
          end
        end
        DEB_PRESS: begin
          if (!f_hit) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (f_code == cand_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DEB_N) begin
              push    = 1'b1;
              state_d = HELD;
            end
          end else begin
            cand_d = f_code;
            cnt_d  = 4'd1;
          end
        end
        HELD: begin
          if (!f_hit) begin
            if (DEB_N == 4'd1) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              state_d = DEB_REL;
              cnt_d   = 4'd1;
            end
          end
        end
        DEB_REL: begin
          if (f_hit) begin
            state_d = HELD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == DEB_N) begin
              state_d = IDLE;
              cnt_d   = '0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    intr_d = push_ok;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cand_q     <= '0;
      acc_hit_q  <= 1'b0;
      acc_code_q <= '0;
      intr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cand_q     <= cand_d;
      acc_hit_q  <= acc_hit_d;
      acc_code_q <= acc_code_d;
      intr_q     <= intr_d;
    end
  end

  key_fifo #(
    .DEPTH (DEPTH),
    .KEY_W (KEY_W)
  ) u_key_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (cand_d),
    .pop       (key_rd),
    .ovf_clr   (ovf_clr),
    .valid     (key_valid),
    .head      (key_data),
    .count     (key_count),
    .overflow  (overflow),
    .push_ok   (push_ok)
  );

  assign intr = intr_q;

endmodule
